srio_status_tx: RTL and testbench

SRIO initiator-side status reporter for the AD/DDC board. It sends the board's current control configuration and a local status byte back to the IFM board as a burst of seven 64-bit NWRITE records. The record layout and data-lane placement match the one the IFM board uses for command writes. It sits between the control-register block and the SRIO initiator request port.

---
 rtl/srio_status_tx.sv | 159 +++++++++++++++
 tb/tb_srio_status_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/srio_status_tx.sv
// Status reporter: sends seven 64-bit NWRITE records (config fields plus status) to the IFM board.
// Optional change-detect triggering is enabled with `define STATUS_TX_CHG_EN.
module srio_status_tx #(
  parameter logic [31:0] REMOTE_BASE = 32'hC000_0100,
  parameter logic [31:0] PERIOD      = 32'd100_000
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [7:0]  cmd_DA,
  input  logic        sig_sel,
  input  logic        clk_sel,
  input  logic        bisuo_sclr,
  input  logic [7:0]  bisuo_st,
  input  logic [7:0]  bisuo_width,
  input  logic [7:0]  status_in,
  input  logic        force_tx,
  input  logic        init_ready,
  output logic        init_req,
  output logic [31:0] init_addr,
  output logic [63:0] init_data,
  output logic [7:0]  init_be,
  output logic        busy,
  output logic [15:0] tx_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      rec_idx_q, rec_idx_d;
  logic            pending_q, pending_d;
  logic [31:0]     timer_q, timer_d;
  logic [6:0][7:0] fields;
  logic [6:0][7:0] snap_q;
  logic [7:0]      rec_byte;
  logic            load;
  logic            expire;
  logic            chg;
  logic            trigger;

  always_comb begin
    fields    = '0;
    fields[0] = cmd_DA;
    fields[1] = {7'd0, sig_sel};
    fields[2] = {7'd0, clk_sel};
    fields[3] = {7'd0, bisuo_sclr};
    fields[4] = bisuo_st;
    fields[5] = bisuo_width;
    fields[6] = status_in;
  end

  assign expire = (PERIOD != 32'd0) && (timer_q == PERIOD - 32'd1);

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (PERIOD == 32'd0 || expire) begin
      timer_d = 32'd0;
    end
  end

`ifdef STATUS_TX_CHG_EN
  // The snapshot doubles as the change-detect shadow: both hold the last captured fields.
  assign chg = (fields != snap_q);
`else
  assign chg = 1'b0;
`endif

  assign trigger = force_tx | expire | chg;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      rec_idx_q <= 3'd0;
      pending_q <= 1'b0;
      timer_q   <= 32'd0;
      snap_q    <= '0;
      tx_cnt    <= 16'd0;
    end else begin
      state_q   <= state_d;
      rec_idx_q <= rec_idx_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      if (load) begin
        snap_q <= fields;
      end
      if (state_q == StDone) begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rec_idx_d = rec_idx_q;
    pending_d = pending_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger || pending_q) begin
          load      = 1'b1;
          pending_d = 1'b0;
          rec_idx_d = 3'd0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (trigger) begin
          pending_d = 1'b1;
        end
        if (init_ready) begin
          if (rec_idx_q == 3'd6) begin
            state_d = StDone;
          end else begin
            rec_idx_d = rec_idx_q + 3'd1;
          end
        end
      end
      StDone: begin
        if (pending_q) begin
          pending_d = 1'b0;
          load      = 1'b1;
          rec_idx_d = 3'd0;
          state_d   = StSend;
        end else begin
          // A trigger landing in DONE is held and picked up from IDLE.
          pending_d = trigger;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (rec_idx_q)
      3'd0:    rec_byte = snap_q[0];
      3'd1:    rec_byte = snap_q[1];
      3'd2:    rec_byte = snap_q[2];
      3'd3:    rec_byte = snap_q[3];
      3'd4:    rec_byte = snap_q[4];
      3'd5:    rec_byte = snap_q[5];
      3'd6:    rec_byte = snap_q[6];
      default: rec_byte = 8'd0;
    endcase
  end

  always_comb begin
    init_req  = (state_q == StSend);
    busy      = (state_q != StIdle);
    init_be   = 8'h00;
    init_addr = 32'd0;
    init_data = 64'd0;
    if (init_req) begin
      init_be   = 8'hFF;
      init_addr = REMOTE_BASE + {26'd0, rec_idx_q, 3'd0};
      init_data = {24'd0, rec_byte, 32'd0};
    end
  end

endmodule

// File: tb/tb_srio_status_tx.sv
// Directed bench for srio_status_tx: record table, handshake stall, pending, timer and reset.
module tb_srio_status_tx;

  logic        clk = 1'b0;
  logic        sys_rst, rst1;
  logic [7:0]  cmd_DA, bisuo_st, bisuo_width, status_in;
  logic        sig_sel, clk_sel, bisuo_sclr, force_tx, init_ready;
  logic        init_req, busy;
  logic [31:0] init_addr;
  logic [63:0] init_data;
  logic [7:0]  init_be;
  logic [15:0] tx_cnt;

  logic        req1, busy1;
  logic [31:0] addr1;
  logic [63:0] data1;
  logic [7:0]  be1;
  logic [15:0] cnt1;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } rec_t;

  rec_t exp_tab [7];

  always #5 clk = ~clk;

  srio_status_tx #(.REMOTE_BASE(32'hC000_0100), .PERIOD(32'd0)) dut (
    .clk(clk), .sys_rst(sys_rst), .cmd_DA(cmd_DA), .sig_sel(sig_sel), .clk_sel(clk_sel),
    .bisuo_sclr(bisuo_sclr), .bisuo_st(bisuo_st), .bisuo_width(bisuo_width),
    .status_in(status_in), .force_tx(force_tx), .init_ready(init_ready),
    .init_req(init_req), .init_addr(init_addr), .init_data(init_data), .init_be(init_be),
    .busy(busy), .tx_cnt(tx_cnt)
  );

  srio_status_tx #(.REMOTE_BASE(32'hC000_0100), .PERIOD(32'd20)) dut_tmr (
    .clk(clk), .sys_rst(rst1), .cmd_DA(cmd_DA), .sig_sel(sig_sel), .clk_sel(clk_sel),
    .bisuo_sclr(bisuo_sclr), .bisuo_st(bisuo_st), .bisuo_width(bisuo_width),
    .status_in(status_in), .force_tx(1'b0), .init_ready(1'b1),
    .init_req(req1), .init_addr(addr1), .init_data(data1), .init_be(be1),
    .busy(busy1), .tx_cnt(cnt1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic pulse_force();
    force_tx = 1'b1;
    @(negedge clk);
    force_tx = 1'b0;
  endtask

  // Called at the negedge showing record 0; returns at the negedge showing DONE.
  task automatic run_burst(input int stall_rec, input int stall_n, input logic [6:0] fmask,
                           input logic mutate);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("req r%0d", i), {63'd0, init_req}, 64'd1);
      check($sformatf("addr r%0d", i), {32'd0, init_addr}, {32'd0, exp_tab[i].addr});
      check($sformatf("data r%0d", i), init_data, exp_tab[i].data);
      check($sformatf("be r%0d", i), {56'd0, init_be}, 64'hFF);
      force_tx = fmask[i];
      if (mutate && i == 0) status_in = 8'hEE;
      if (i == stall_rec) begin
        init_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          force_tx = 1'b0;
          check($sformatf("stall req %0d", k), {63'd0, init_req}, 64'd1);
          check($sformatf("stall addr %0d", k), {32'd0, init_addr}, {32'd0, exp_tab[i].addr});
          check($sformatf("stall data %0d", k), init_data, exp_tab[i].data);
        end
        init_ready = 1'b1;
      end
      @(negedge clk);
    end
    force_tx = 1'b0;
    check("done req", {63'd0, init_req}, 64'd0);
    check("done busy", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    int rises;
    logic prev;
    logic seen;

    sys_rst = 1'b1; rst1 = 1'b1;
    cmd_DA = 8'h00; sig_sel = 1'b0; clk_sel = 1'b0; bisuo_sclr = 1'b0;
    bisuo_st = 8'h00; bisuo_width = 8'h00; status_in = 8'h00;
    force_tx = 1'b0; init_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst req", {63'd0, init_req}, 64'd0);
    check("rst addr", {32'd0, init_addr}, 64'd0);
    check("rst data", init_data, 64'd0);
    check("rst be", {56'd0, init_be}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst cnt", {48'd0, tx_cnt}, 64'd0);
    sys_rst = 1'b0;
    @(negedge clk);

    // Change detect on sig_sel while idle
    for (int i = 0; i < 7; i++) begin
      exp_tab[i].addr = 32'hC000_0100 + 32'(8 * i);
      exp_tab[i].data = 64'd0;
    end
    exp_tab[1].data = 64'h0000_0001_0000_0000;
    sig_sel = 1'b1;
    @(negedge clk);
`ifdef STATUS_TX_CHG_EN
    run_burst(-1, 0, 7'd0, 1'b0);
    exp_cnt++;
    @(negedge clk);
    check("chg cnt", {48'd0, tx_cnt}, 64'(exp_cnt));
    check("chg idle", {63'd0, busy}, 64'd0);
`else
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (init_req) seen = 1'b1;
      @(negedge clk);
    end
    check("nochg req", {63'd0, seen}, 64'd0);
    sig_sel = 1'b0;

    // Main record table
    cmd_DA = 8'h5A; sig_sel = 1'b1; clk_sel = 1'b0; bisuo_sclr = 1'b1;
    bisuo_st = 8'h10; bisuo_width = 8'h22; status_in = 8'h03;
    exp_tab[0] = '{32'hC000_0100, 64'h0000_005A_0000_0000};
    exp_tab[1] = '{32'hC000_0108, 64'h0000_0001_0000_0000};
    exp_tab[2] = '{32'hC000_0110, 64'h0000_0000_0000_0000};
    exp_tab[3] = '{32'hC000_0118, 64'h0000_0001_0000_0000};
    exp_tab[4] = '{32'hC000_0120, 64'h0000_0010_0000_0000};
    exp_tab[5] = '{32'hC000_0128, 64'h0000_0022_0000_0000};
    exp_tab[6] = '{32'hC000_0130, 64'h0000_0003_0000_0000};
    @(negedge clk);
    pulse_force();
    run_burst(-1, 0, 7'd0, 1'b0);
    exp_cnt++;
    @(negedge clk);
    check("t1 cnt", {48'd0, tx_cnt}, 64'(exp_cnt));
    check("t1 idle req", {63'd0, init_req}, 64'd0);
    check("t1 idle be", {56'd0, init_be}, 64'd0);
    check("t1 idle busy", {63'd0, busy}, 64'd0);

    // Stall on record 2 with input change mid-burst
    pulse_force();
    run_burst(2, 5, 7'd0, 1'b1);
    exp_cnt++;
    @(negedge clk);
    check("t2 cnt", {48'd0, tx_cnt}, 64'(exp_cnt));
    check("t2 idle", {63'd0, busy}, 64'd0);
    status_in = 8'h03;

    // Three forces during one burst -> exactly one follow-on
    pulse_force();
    run_burst(-1, 0, 7'b0101010, 1'b0);
    exp_cnt++;
    @(negedge clk);
    check("t3 cnt1", {48'd0, tx_cnt}, 64'(exp_cnt));
    run_burst(-1, 0, 7'd0, 1'b0);
    exp_cnt++;
    @(negedge clk);
    check("t3 cnt2", {48'd0, tx_cnt}, 64'(exp_cnt));
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (init_req) seen = 1'b1;
      @(negedge clk);
    end
    check("t3 no third", {63'd0, seen}, 64'd0);

    // Reset mid-burst on record 3
    pulse_force();
    repeat (3) @(negedge clk);
    check("t4 at r3", {32'd0, init_addr}, 64'hC000_0118);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("t4 req", {63'd0, init_req}, 64'd0);
    check("t4 cnt", {48'd0, tx_cnt}, 64'd0);
    check("t4 busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (init_req) seen = 1'b1;
    end
    check("t4 quiet", {63'd0, seen}, 64'd0);

    // Periodic timer, PERIOD=20
    rst1 = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (req1 && !prev) begin
        rises++;
        check($sformatf("tmr start %0d", rises), 64'(k), 64'(20 * rises));
        check($sformatf("tmr addr %0d", rises), {32'd0, addr1}, 64'hC000_0100);
      end
      prev = req1;
    end
    check("tmr bursts", 64'(rises), 64'd5);
    check("tmr cnt", {48'd0, cnt1}, 64'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
